// File: rtl/mult_div_e.sv
// HI/LO multiply-divide unit: result computed at acceptance, committed after a fixed latency.
// state  | meaning
// S_IDLE | ready; accepts mult/div/mthi/mtlo requests
// S_MULT | mult/multu in flight, counting down from 5
// S_DIV  | div/divu in flight, counting down from 10
module mult_div_e (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDop,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_result;
  logic        r_div0;

  logic        w_accept;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_signed_div;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_divisor;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_accept = Start && (r_state == S_IDLE) && (MDop >= 4'd1) && (MDop <= 4'd6);

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
  assign w_prod_u = {32'd0, SrcA} * {32'd0, SrcB};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_signed_div = (MDop == 4'd3);
  assign w_neg_a      = w_signed_div & SrcA[31];
  assign w_neg_b      = w_signed_div & SrcB[31];
  assign w_mag_a      = w_neg_a ? -SrcA : SrcA;
  assign w_divisor    = (SrcB == 32'd0) ? 32'd1 : (w_neg_b ? -SrcB : SrcB);
  assign w_q_mag      = w_mag_a / w_divisor;
  assign w_r_mag      = w_mag_a % w_divisor;
  assign w_q          = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
  assign w_r          = w_neg_a ? -w_r_mag : w_r_mag;

  assign Busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_result <= 64'd0;
      r_div0   <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (MDop)
              4'd1: begin
                r_result <= w_prod_s;
                r_div0   <= 1'b0;
                r_cnt    <= 4'd5;
                r_state  <= S_MULT;
              end
              4'd2: begin
                r_result <= w_prod_u;
                r_div0   <= 1'b0;
                r_cnt    <= 4'd5;
                r_state  <= S_MULT;
              end
              4'd3, 4'd4: begin
                r_result <= {w_r, w_q};
                r_div0   <= (SrcB == 32'd0);
                r_cnt    <= 4'd10;
                r_state  <= S_DIV;
              end
              4'd5:    HI <= SrcA;
              4'd6:    LO <= SrcA;
              default: ;
            endcase
          end
        end
        default: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_IDLE;
            if (!r_div0) begin
              HI <= r_result[63:32];
              LO <= r_result[31:0];
            end
          end
        end
      endcase
    end
  end

endmodule
